// File: rtl/control_rw_burst.sv
// Burst sequencer for memory reads and writes through a serial transceiver, with a WaitTransferDone timeout.
// Done and Error are registered pulses; Active=0 stalls the flow, and ValidCmd is ignored while Busy.
module control_rw_burst #(
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               ValidCmd,
  input  logic               RW,
  input  logic               Mode,
  input  logic               Active,
  input  logic [BURST_W-1:0] BurstLen,
  input  logic [ADDR_W-1:0]  BaseAddr,
  input  logic               TransferDone,
  output logic               CmdAccept,
  output logic               AccessMem,
  output logic               RWMem,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic               SampleData,
  output logic               TransferData,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               rw_q;
  logic               mode_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beat_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               done_q;
  logic               error_q;
  logic               beat_inc;
  logic               finish;
  logic               abort;
  logic               last_beat;
  logic               tmo_hit;
  logic               step_ok;

  assign step_ok   = Active && !TransferDone;
  assign last_beat = (beat_q == len_q);
  // tmo_q counts WaitTransferDone cycles already elapsed, so the limit is hit during the TIMEOUT-th one.
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  assign CmdAccept = ResetN && (state_q == S_IDLE) && ValidCmd && Active;

  always_comb begin
    state_d  = state_q;
    beat_inc = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CmdAccept) begin
          if (!Mode)   state_d = S_SAMPLE;
          else if (RW) state_d = S_WRITE;
          else         state_d = S_READ;
        end
      end
      S_READ:   if (step_ok) state_d = S_SAMPLE;
      S_SAMPLE: if (step_ok) state_d = S_START;
      S_START:  if (step_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (TransferDone) begin
          if (!mode_q || last_beat) begin
            finish = 1'b1;
          end else begin
            beat_inc = 1'b1;
            state_d  = S_READ;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      S_WRITE: begin
        if (Active) begin
          if (last_beat) finish   = 1'b1;
          else           beat_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (finish || abort) state_d = S_IDLE;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      error_q <= abort;
      if (CmdAccept) begin
        rw_q   <= RW;
        mode_q <= Mode;
        len_q  <= BurstLen;
        addr_q <= BaseAddr;
        beat_q <= '0;
      end else if (beat_inc) begin
        addr_q <= addr_q + 1'b1;
        beat_q <= beat_q + 1'b1;
      end
      if (state_q == S_WAIT) tmo_q <= tmo_q + 1'b1;
      else                   tmo_q <= '0;
    end
  end

  assign AccessMem    = (state_q == S_READ) || ((state_q == S_WRITE) && Active);
  assign RWMem        = (state_q == S_WRITE) && Active && rw_q;
  assign MemAddr      = addr_q;
  assign SampleData   = (state_q == S_SAMPLE);
  assign TransferData = (state_q == S_START);
  assign Busy         = (state_q != S_IDLE);
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_control_rw_burst.sv
// Bench for control_rw_burst: directed burst scenarios plus random traffic against a beats-remaining model.
module tb_control_rw_burst;
  localparam int ADDR_W  = 8;
  localparam int BURST_W = 4;
  localparam int TIMEOUT = 4;

  localparam int P_IDLE = 0, P_RD = 1, P_SMP = 2, P_XFR = 3, P_WAIT = 4, P_WR = 5;

  logic               Clk = 1'b0;
  logic               ResetN = 1'b0;
  logic               ValidCmd = 1'b0;
  logic               RW = 1'b0;
  logic               Mode = 1'b0;
  logic               Active = 1'b0;
  logic [BURST_W-1:0] BurstLen = '0;
  logic [ADDR_W-1:0]  BaseAddr = '0;
  logic               TransferDone = 1'b0;
  logic               CmdAccept, AccessMem, RWMem, SampleData, TransferData, Busy, Done, Error;
  logic [ADDR_W-1:0]  MemAddr;

  control_rw_burst #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .ResetN(ResetN), .ValidCmd(ValidCmd), .RW(RW), .Mode(Mode), .Active(Active),
    .BurstLen(BurstLen), .BaseAddr(BaseAddr), .TransferDone(TransferDone),
    .CmdAccept(CmdAccept), .AccessMem(AccessMem), .RWMem(RWMem), .MemAddr(MemAddr),
    .SampleData(SampleData), .TransferData(TransferData), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Reference: phase of the command, beats still owed after the current one, cycles spent waiting.
  int          ph, left, wait_n;
  logic [7:0]  m_addr;
  logic        m_done, m_err;
  int          checks = 0, failures = 0;
  int          td_at = 1;
  bit          td_rand = 0;

  int          n_busy, n_sample, n_xfer, n_access, n_noacc, n_quiet, n_done, n_err;
  logic [7:0]  rd_q[$];
  logic [7:0]  wr_q[$];

  task automatic model_reset();
    ph = P_IDLE; left = 0; wait_n = 0; m_addr = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    if (!ResetN) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    case (ph)
      P_IDLE: if (ValidCmd && Active) begin
        m_addr = BaseAddr;
        left   = Mode ? int'(BurstLen) : 0;
        ph     = !Mode ? P_SMP : (RW ? P_WR : P_RD);
      end
      P_RD:  if (Active && !TransferDone) ph = P_SMP;
      P_SMP: if (Active && !TransferDone) ph = P_XFR;
      P_XFR: if (Active && !TransferDone) begin ph = P_WAIT; wait_n = 0; end
      P_WAIT: begin
        if (TransferDone) begin
          if (left == 0) begin ph = P_IDLE; m_done = 1'b1; end
          else begin left--; m_addr++; ph = P_RD; end
        end else begin
          wait_n++;
          if (TIMEOUT != 0 && wait_n == TIMEOUT) begin ph = P_IDLE; m_err = 1'b1; end
        end
      end
      P_WR: if (Active) begin
        if (left == 0) begin ph = P_IDLE; m_done = 1'b1; end
        else begin left--; m_addr++; end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [15:0] got, exp;
    got = {CmdAccept, AccessMem, RWMem, SampleData, TransferData, Busy, Done, Error, MemAddr};
    exp = {ResetN && ph == P_IDLE && ValidCmd && Active,
           ph == P_RD || (ph == P_WR && Active), ph == P_WR && Active,
           ph == P_SMP, ph == P_XFR, ph != P_IDLE, m_done, m_err, m_addr};
    check("outputs{acc,mem,rw,smp,xfr,busy,done,err,addr}", int'(got), int'(exp));
  endtask

  task automatic observe();
    if (Busy) n_busy++;
    if (SampleData) n_sample++;
    if (TransferData) n_xfer++;
    if (AccessMem) n_access++;
    if (Busy && !AccessMem) n_noacc++;
    if (Busy && !AccessMem && !SampleData && !TransferData) n_quiet++;
    if (Done) n_done++;
    if (Error) n_err++;
    if (AccessMem && !RWMem) rd_q.push_back(MemAddr);
    if (AccessMem && RWMem) wr_q.push_back(MemAddr);
  endtask

  task automatic clear_obs();
    n_busy = 0; n_sample = 0; n_xfer = 0; n_access = 0; n_noacc = 0; n_quiet = 0;
    n_done = 0; n_err = 0; rd_q.delete(); wr_q.delete();
  endtask

  // Entered at posedge+1; drives TransferDone, compares at negedge, advances the model at posedge.
  task automatic tick();
    if (!td_rand) TransferDone = (td_at > 0 && ph == P_WAIT && wait_n == td_at - 1);
    @(negedge Clk);
    compare();
    observe();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic issue(input logic rw, input logic mode, input int bl, input int ba);
    clear_obs();
    ValidCmd = 1'b1; RW = rw; Mode = mode; Active = 1'b1;
    BurstLen = BURST_W'(bl); BaseAddr = ADDR_W'(ba);
    tick();
    // Scramble the command fields: the running burst must not follow them.
    ValidCmd = 1'b0; RW = ~rw; Mode = ~mode; BurstLen = ~BurstLen; BaseAddr = 8'h77;
  endtask

  task automatic run_to_idle(input int lim);
    int n = 0;
    while (ph != P_IDLE && n < lim) begin tick(); n++; end
    check("completion_within_bound", int'(ph == P_IDLE), 1);
    tick();
  endtask

  task automatic check_q(input string name, input logic [7:0] q[$], input logic [7:0] e[4], input int cnt);
    check({name, "_count"}, q.size(), cnt);
    for (int i = 0; i < cnt; i++)
      check({name, "_addr"}, (i < q.size()) ? int'(q[i]) : -1, int'(e[i]));
  endtask

  logic [7:0] exp_a[4];

  initial begin
    model_reset();
    clear_obs();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_busy", Busy, 0);
    check("reset_memaddr", MemAddr, 0);
    check("reset_done_error", {Done, Error, AccessMem}, 0);
    ResetN = 1'b1;

    // Read burst of 3 right after reset release.
    td_at = 1;
    issue(1'b0, 1'b1, 2, 8'h10);
    run_to_idle(60);
    exp_a = '{8'h10, 8'h11, 8'h12, 8'h00};
    check_q("read_burst", rd_q, exp_a, 3);
    check("read_done", n_done, 1);
    check("read_error", n_err, 0);
    check("read_busy_after", Busy, 0);

    // Write burst wrapping the address space, with a two-cycle stall.
    issue(1'b1, 1'b1, 3, 8'hFE);
    tick(); tick();
    Active = 1'b0; tick(); tick();
    Active = 1'b1;
    run_to_idle(20);
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check_q("write_wrap", wr_q, exp_a, 4);
    check("write_busy_cycles", n_busy, 6);
    check("write_stall_cycles", n_noacc, 2);
    check("write_done", n_done, 1);

    // Transceiver-only: BurstLen ignored, single beat.
    issue(1'b0, 1'b0, 5, 8'h20);
    run_to_idle(20);
    check("xcvr_sample", n_sample, 1);
    check("xcvr_transfer", n_xfer, 1);
    check("xcvr_access", n_access, 0);
    check("xcvr_done", n_done, 1);

    // Timeout with TransferDone never arriving.
    td_at = 0;
    issue(1'b0, 1'b1, 0, 8'h30);
    run_to_idle(20);
    check("tmo_wait_cycles", n_quiet, 4);
    check("tmo_error", n_err, 1);
    check("tmo_done", n_done, 0);

    // TransferDone on the 4th wait cycle wins over the timeout.
    td_at = 4;
    issue(1'b0, 1'b1, 0, 8'h31);
    run_to_idle(20);
    check("tmo_race_wait_cycles", n_quiet, 4);
    check("tmo_race_done", n_done, 1);
    check("tmo_race_error", n_err, 0);

    // Reset during the second write beat, then an immediate read.
    td_at = 1;
    issue(1'b1, 1'b1, 5, 8'h40);
    tick();
    ValidCmd = 1'b1; RW = 1'b0; Mode = 1'b1; BurstLen = '0; BaseAddr = 8'h33;
    ResetN = 1'b0;
    model_reset();
    #1;
    check("midreset_outputs", {CmdAccept, AccessMem, RWMem, SampleData, TransferData, Busy, Done, Error}, 0);
    check("midreset_memaddr", MemAddr, 0);
    tick();
    ResetN = 1'b1;
    clear_obs();
    tick();
    ValidCmd = 1'b0;
    check("post_reset_accept_busy", Busy, 1);
    run_to_idle(20);
    exp_a = '{8'h33, 8'h00, 8'h00, 8'h00};
    check_q("post_reset_read", rd_q, exp_a, 1);
    check("post_reset_done", n_done, 1);

    // Random traffic, including occasional asynchronous resets.
    td_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      ValidCmd     = ($urandom_range(0, 1) == 1);
      RW           = $urandom_range(0, 1);
      Mode         = ($urandom_range(0, 3) != 0);
      Active       = ($urandom_range(0, 4) != 0);
      BurstLen     = BURST_W'($urandom);
      BaseAddr     = ADDR_W'($urandom);
      TransferDone = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 299) == 0) begin
        ResetN = 1'b0;
        model_reset();
      end else begin
        ResetN = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
